// File: rtl/jpeg_dequant_pipe_if.sv
// Handshake bundle for jpeg_dequant_pipe: DQT byte stream, coefficient input
// and valid/yumi output port.
interface jpeg_dequant_pipe_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 16,
    parameter int ID_W   = 32
);
    logic              cfg_valid_i;
    logic [7:0]        cfg_data_i;
    logic              cfg_last_i;
    logic              cfg_accept_o;
    logic              inport_valid_i;
    logic [DATA_W-1:0] inport_data_i;
    logic [5:0]        inport_idx_i;
    logic [ID_W-1:0]   inport_id_i;
    logic              inport_eob_i;
    logic              ready_o;
    logic              v_o;
    logic              yumi_i;
    logic [OUT_W-1:0]  outport_data_o;
    logic [5:0]        outport_idx_o;
    logic [ID_W-1:0]   outport_id_o;
    logic              outport_eob_o;

    modport slave (
        input  cfg_valid_i, cfg_data_i, cfg_last_i,
        input  inport_valid_i, inport_data_i, inport_idx_i, inport_id_i, inport_eob_i,
        input  yumi_i,
        output cfg_accept_o, ready_o, v_o,
        output outport_data_o, outport_idx_o, outport_id_o, outport_eob_o
    );

    modport master (
        output cfg_valid_i, cfg_data_i, cfg_last_i,
        output inport_valid_i, inport_data_i, inport_idx_i, inport_id_i, inport_eob_i,
        output yumi_i,
        input  cfg_accept_o, ready_o, v_o,
        input  outport_data_o, outport_idx_o, outport_id_o, outport_eob_o
    );
endinterface

// File: rtl/jpeg_dequant_pipe.sv
// Dequantiser / de-zigzag stage: DQT parser into quant tables, 2-stage
// multiply-saturate pipeline, credit-controlled output FIFO with valid/yumi.
module jpeg_dequant_pipe #(
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 16,
    parameter int ID_W       = 32,
    parameter int NUM_COMP   = 4,
    parameter int NUM_TABLES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     img_start_i,
    input  logic [NUM_COMP*$clog2(NUM_TABLES)-1:0]   img_dqt_table_i,
    output logic                                     cfg_err_o,
    jpeg_dequant_pipe_if.slave                       bus
);
    localparam int TSEL_W = $clog2(NUM_TABLES);
    localparam int COMP_W = $clog2(NUM_COMP);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PROD_W = DATA_W + 17;
    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    // Natural (row-major) position of each zigzag index.
    localparam logic [5:0] ZZ_NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10, 6'd17, 6'd24, 6'd32, 6'd25, 6'd18,
        6'd11, 6'd4,  6'd5,  6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd27, 6'd20,
        6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28, 6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43,
        6'd36, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51, 6'd58, 6'd59, 6'd52, 6'd45,
        6'd38, 6'd31, 6'd39, 6'd46, 6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

    typedef enum logic [1:0] {ST_HDR, ST_HI, ST_LO} cfg_state_e;
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [5:0]       idx;
        logic [ID_W-1:0]  id;
        logic             eob;
    } fifo_ent_t;

    cfg_state_e         r_state, w_state_nx;
    logic               r_p16, r_bad, r_err;
    logic [TSEL_W-1:0]  r_tq;
    logic [5:0]         r_n;
    logic [7:0]         r_hi;
    logic               w_hdr_bad, w_tab_we, w_err_set;
    logic [15:0]        r_qtab [NUM_TABLES*64];
    logic [TSEL_W+5:0]  w_waddr, w_raddr;
    logic [COMP_W-1:0]  w_comp;
    logic [TSEL_W-1:0]  w_sel;

    assign w_hdr_bad = (bus.cfg_data_i[7:4] > 4'd1) ||
                       ({1'b0, bus.cfg_data_i[3:0]} >= 5'(NUM_TABLES));

    always_comb begin
        w_state_nx = r_state;
        w_tab_we   = 1'b0;
        w_err_set  = 1'b0;
        if (bus.cfg_valid_i) begin
            case (r_state)
                ST_HDR: begin
                    w_err_set  = w_hdr_bad;
                    w_state_nx = (bus.cfg_data_i[7:4] == 4'd1) ? ST_HI : ST_LO;
                end
                ST_HI:   w_state_nx = ST_LO;
                ST_LO: begin
                    w_tab_we   = !r_bad;
                    w_state_nx = (r_n == 6'd63) ? ST_HDR : (r_p16 ? ST_HI : ST_LO);
                end
                default: w_state_nx = ST_HDR;
            endcase
            // A segment may only end right after a table's 64th entry.
            if (bus.cfg_last_i) begin
                w_state_nx = ST_HDR;
                if (!(r_state == ST_LO && r_n == 6'd63)) w_err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_HDR;
            r_p16   <= 1'b0;
            r_bad   <= 1'b0;
            r_tq    <= '0;
            r_n     <= '0;
            r_hi    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_err   <= (r_err & ~img_start_i) | w_err_set;
            if (bus.cfg_valid_i) begin
                case (r_state)
                    ST_HDR: begin
                        r_p16 <= (bus.cfg_data_i[7:4] == 4'd1);
                        r_tq  <= bus.cfg_data_i[TSEL_W-1:0];
                        r_bad <= w_hdr_bad;
                        r_n   <= '0;
                    end
                    ST_HI:   r_hi <= bus.cfg_data_i;
                    default: r_n  <= r_n + 6'd1;
                endcase
            end
        end
    end

    assign bus.cfg_accept_o = 1'b1;
    assign cfg_err_o        = r_err;

    assign w_comp  = bus.inport_id_i[ID_W-1 -: COMP_W];
    always_comb begin
        w_sel = '0;
        for (int unsigned c = 0; c < NUM_COMP; c++)
            if (w_comp == COMP_W'(c)) w_sel = img_dqt_table_i[c*TSEL_W +: TSEL_W];
    end
    assign w_waddr = {r_tq, r_n};
    assign w_raddr = {w_sel, bus.inport_idx_i};

    // Pipeline, credits and FIFO.
    logic                     r_s1_v, r_s1_eob, r_s2_v;
    logic signed [DATA_W-1:0] r_s1_data;
    logic [5:0]               r_s1_idx;
    logic [ID_W-1:0]          r_s1_id;
    logic [15:0]              r_s1_q;
    fifo_ent_t                r_s2;
    fifo_ent_t                r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wptr, r_rptr;
    logic [CNT_W-1:0]         r_count;
    logic [CNT_W:0]           w_used;
    logic                     w_ready, w_accept, w_push, w_pop;
    logic signed [PROD_W-1:0] w_a, w_b, w_prod;
    logic [OUT_W-1:0]         w_sat;

    assign w_used   = {1'b0, r_count} + (CNT_W+1)'(r_s1_v) + (CNT_W+1)'(r_s2_v);
    assign w_ready  = !img_start_i && !w_tab_we && (w_used < (CNT_W+1)'(FIFO_DEPTH));
    assign w_accept = bus.inport_valid_i && w_ready;
    assign w_push   = r_s2_v && !img_start_i;
    assign w_pop    = bus.yumi_i && (r_count != '0);
    assign bus.ready_o = w_ready;

    always_ff @(posedge clk_i) begin
        if (w_tab_we) r_qtab[w_waddr] <= {r_p16 ? r_hi : 8'h00, bus.cfg_data_i};
        if (w_accept) r_s1_q <= r_qtab[w_raddr];
    end

    assign w_a    = PROD_W'(r_s1_data);
    assign w_b    = PROD_W'({1'b0, r_s1_q});
    assign w_prod = w_a * w_b;
    always_comb begin
        w_sat = w_prod[OUT_W-1:0];
        if (w_prod > SAT_MAX)      w_sat = SAT_MAX[OUT_W-1:0];
        else if (w_prod < SAT_MIN) w_sat = SAT_MIN[OUT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_s1_idx  <= '0;
            r_s1_id   <= '0;
            r_s1_eob  <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s2      <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            r_s1_v <= w_accept;
            r_s2_v <= r_s1_v && !img_start_i;
            if (w_accept) begin
                r_s1_data <= bus.inport_data_i;
                r_s1_idx  <= bus.inport_idx_i;
                r_s1_id   <= bus.inport_id_i;
                r_s1_eob  <= bus.inport_eob_i;
            end
            if (r_s1_v) r_s2 <= '{data: w_sat, idx: ZZ_NAT[r_s1_idx], id: r_s1_id, eob: r_s1_eob};
            if (img_start_i) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_fifo[r_wptr] <= r_s2;
                    r_wptr         <= r_wptr + PTR_W'(1);
                end
                if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    assign bus.v_o            = (r_count != '0);
    assign bus.outport_data_o = r_fifo[r_rptr].data;
    assign bus.outport_idx_o  = r_fifo[r_rptr].idx;
    assign bus.outport_id_o   = r_fifo[r_rptr].id;
    assign bus.outport_eob_o  = r_fifo[r_rptr].eob;
endmodule

// File: tb/tb_jpeg_dequant_pipe.sv
// Scoreboard bench for jpeg_dequant_pipe: stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever it takes an output.
module tb_jpeg_dequant_pipe;
    localparam int DATA_W = 16, OUT_W = 16, ID_W = 32;
    localparam int NUM_COMP = 4, NUM_TABLES = 4, FIFO_DEPTH = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  idx;
        logic [31:0] id;
        logic        eob;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       img_start = 1'b0;
    logic [7:0] dqt_sel = 8'b11_10_01_00;
    logic       cfg_err;
    out_t       exp_q[$];
    out_t       mon_got, mon_exp;
    int         n_pass = 0, n_total = 0;
    bit         yumi_en = 1'b0;
    int         nat[64];
    int         j;
    bit         acc, seen_v;

    always #5 clk = ~clk;

    jpeg_dequant_pipe_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ID_W(ID_W)) bus ();

    jpeg_dequant_pipe #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .ID_W(ID_W),
        .NUM_COMP(NUM_COMP), .NUM_TABLES(NUM_TABLES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .img_start_i(img_start),
        .img_dqt_table_i(dqt_sel), .cfg_err_o(cfg_err), .bus(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: takes the head whenever allowed and compares it with the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.v_o && yumi_en) begin
            mon_got = {bus.outport_data_o, bus.outport_idx_o, bus.outport_id_o, bus.outport_eob_o};
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got 0x%0h, expected no output", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out", 64'(mon_got), 64'(mon_exp));
            end
            bus.yumi_i = 1'b1;
        end else begin
            bus.yumi_i = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [7:0] b, input bit last);
        bus.cfg_valid_i = 1'b1;
        bus.cfg_data_i  = b;
        bus.cfg_last_i  = last;
        tick();
        bus.cfg_valid_i = 1'b0;
        bus.cfg_last_i  = 1'b0;
    endtask

    task automatic load(input logic [7:0] hdr, input int start, input int inc, input bit last);
        send_cfg(hdr, 1'b0);
        for (int i = 0; i < 64; i++) send_cfg(8'(start + inc * i), last && (i == 63));
    endtask

    task automatic send_coef(input logic [15:0] d, input logic [5:0] idx, input logic [31:0] id,
                             input logic eob, input logic [15:0] exp_data);
        bit ok;
        out_t e;
        ok = 1'b0;
        bus.inport_valid_i = 1'b1;
        bus.inport_data_i  = d;
        bus.inport_idx_i   = idx;
        bus.inport_id_i    = id;
        bus.inport_eob_i   = eob;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            ok = bus.ready_o;
            if (ok) begin
                e = {exp_data, 6'(nat[idx]), id, eob};
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        bus.inport_valid_i = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: idx %0d never accepted, expected acceptance", idx);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !bus.v_o) break;
            tick();
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_start();
        img_start = 1'b1;
        tick();
        img_start = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int r, c;
        r = 0;
        c = 0;
        for (int k = 0; k < 64; k++) begin
            nat[k] = r * 8 + c;
            if ((r + c) % 2 == 0) begin
                if (c == 7) r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7) c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end
        bus.cfg_valid_i = 0; bus.cfg_data_i = 0; bus.cfg_last_i = 0;
        bus.inport_valid_i = 0; bus.inport_data_i = 0; bus.inport_idx_i = 0;
        bus.inport_id_i = 0; bus.inport_eob_i = 0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_v", 64'(bus.v_o), 64'd0);
        chk("rst_err", 64'(cfg_err), 64'd0);
        chk("rst_accept", 64'(bus.cfg_accept_o), 64'd1);
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_out", 64'({bus.outport_data_o, bus.outport_idx_o, bus.outport_id_o, bus.outport_eob_o}), 64'd0);
        #20 rst_n = 1'b1;
        tick();

        // 8-bit table 0 = 1..64, data 2 -> 2*(k+1) at natural position.
        load(8'h00, 1, 1, 1'b1);
        chk("t1_err", 64'(cfg_err), 64'd0);
        send_coef(16'd2, 6'd0, 32'd0, 1'b0, 16'd2);
        chk("lat_t0", 64'(bus.v_o), 64'd0);
        tick();
        chk("lat_t1", 64'(bus.v_o), 64'd0);
        tick();
        chk("lat_t2", 64'(bus.v_o), 64'd1);
        yumi_en = 1'b1;
        for (int k = 1; k < 64; k++)
            send_coef(16'd2, 6'(k), 32'(k), k == 63, 16'(2 * (k + 1)));
        drain();

        // 16-bit table 1 = 0x0100 everywhere, saturation both ways.
        send_cfg(8'h11, 1'b0);
        for (int i = 0; i < 64; i++) begin
            send_cfg(8'h01, 1'b0);
            send_cfg(8'h00, i == 63);
        end
        chk("t2_err", 64'(cfg_err), 64'd0);
        send_coef(16'h0100, 6'd3, 32'h4000_0001, 1'b0, 16'h7FFF);
        send_coef(-16'sd200, 6'd10, 32'h4000_0002, 1'b0, 16'h8000);
        send_coef(16'd1, 6'd63, 32'h4000_0003, 1'b1, 16'd256);
        drain();

        // Two tables in one segment.
        load(8'h02, 3, 0, 1'b0);
        load(8'h03, 5, 0, 1'b1);
        chk("t3_err", 64'(cfg_err), 64'd0);
        send_coef(16'd7, 6'd5, 32'h8000_0005, 1'b0, 16'd21);
        send_coef(-16'sd4, 6'd63, 32'hC000_0007, 1'b1, 16'hFFEC);
        drain();

        // Out-of-range Tq: error, writes suppressed.
        load(8'h05, 9, 0, 1'b1);
        chk("badtq_err", 64'(cfg_err), 64'd1);
        send_coef(16'd1, 6'd0, 32'h4000_0000, 1'b0, 16'd256);
        drain();
        pulse_start();
        chk("badtq_clr", 64'(cfg_err), 64'd0);

        // Early cfg_last on byte 10: error, partial writes kept.
        send_cfg(8'h00, 1'b0);
        for (int i = 0; i < 9; i++) send_cfg(8'd20, i == 8);
        chk("early_err", 64'(cfg_err), 64'd1);
        send_coef(16'd1, 6'd0, 32'd0, 1'b0, 16'd20);
        send_coef(16'd1, 6'd8, 32'd0, 1'b0, 16'd20);
        send_coef(16'd1, 6'd9, 32'd0, 1'b0, 16'd10);
        drain();
        pulse_start();
        chk("early_clr", 64'(cfg_err), 64'd0);

        // Backpressure: no pops, 10 offered, only FIFO_DEPTH accepted.
        yumi_en = 1'b0;
        j = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.inport_valid_i = 1'b1;
            bus.inport_data_i  = 16'(j + 1);
            bus.inport_idx_i   = 6'(j);
            bus.inport_id_i    = 32'h8000_0000 | 32'(j);
            bus.inport_eob_i   = 1'b0;
            #1;
            acc = bus.ready_o;
            if (acc) exp_q.push_back({16'(3 * (j + 1)), 6'(nat[j]), 32'h8000_0000 | 32'(j), 1'b0});
            tick();
            if (acc) j++;
        end
        chk("bp_accepted", 64'(j), 64'd4);
        chk("bp_ready", 64'(bus.ready_o), 64'd0);
        yumi_en = 1'b1;
        for (int k = j; k < 10; k++)
            send_coef(16'(k + 1), 6'(k), 32'h8000_0000 | 32'(k), k == 9, 16'(3 * (k + 1)));
        drain();

        // Cfg write and coefficient in the same cycle.
        send_cfg(8'h00, 1'b0);
        bus.cfg_valid_i = 1'b1; bus.cfg_data_i = 8'd50; bus.cfg_last_i = 1'b0;
        bus.inport_valid_i = 1'b1; bus.inport_data_i = 16'd1;
        bus.inport_idx_i = 6'd0; bus.inport_id_i = 32'd0; bus.inport_eob_i = 1'b0;
        #1;
        chk("wr_blocks_ready", 64'(bus.ready_o), 64'd0);
        tick();
        bus.cfg_valid_i = 1'b0;
        #1;
        chk("ready_after_wr", 64'(bus.ready_o), 64'd1);
        send_coef(16'd1, 6'd0, 32'd0, 1'b0, 16'd50);
        for (int i = 1; i < 64; i++) send_cfg(8'd1, i == 63);
        chk("t7_err", 64'(cfg_err), 64'd0);
        drain();

        // Flush with FIFO partly full and stages occupied.
        yumi_en = 1'b0;
        for (int k = 0; k < 4; k++) send_coef(16'd1, 6'(k), 32'd0, 1'b0, 16'd1);
        img_start = 1'b1;
        bus.inport_valid_i = 1'b1;
        #1;
        chk("start_ready", 64'(bus.ready_o), 64'd0);
        tick();
        img_start = 1'b0;
        bus.inport_valid_i = 1'b0;
        exp_q.delete();
        chk("flush_v", 64'(bus.v_o), 64'd0);
        seen_v = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_v |= bus.v_o;
        end
        chk("flush_quiet", 64'(seen_v), 64'd0);
        yumi_en = 1'b1;
        send_coef(16'd1, 6'd1, 32'd0, 1'b1, 16'd1);
        drain();

        // Async reset mid-stream.
        send_cfg(8'h05, 1'b1);
        chk("pre_rst_err", 64'(cfg_err), 64'd1);
        yumi_en = 1'b0;
        send_coef(16'd1, 6'd0, 32'd0, 1'b0, 16'd50);
        send_coef(16'd2, 6'd0, 32'd0, 1'b0, 16'd100);
        tick(); tick(); tick();
        chk("pre_rst_v", 64'(bus.v_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_v", 64'(bus.v_o), 64'd0);
        chk("arst_err", 64'(cfg_err), 64'd0);
        chk("arst_ready", 64'(bus.ready_o), 64'd1);
        chk("arst_out", 64'({bus.outport_data_o, bus.outport_idx_o, bus.outport_id_o, bus.outport_eob_o}), 64'd0);
        exp_q.delete();
        #20 rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
